// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Only the controller state encoding lives here; the step counter width
// is derived locally from the operand width.
package mult_pkg;

    // Controller states: wait for a request, iterate, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mult_pkg

// File: rtl/sumador_n.sv
// n-bit ripple-carry adder built from a chain of full adders.
// Carry-in and carry-out are exposed so the adder can be cascaded or,
// as in the multiplier, have its carry-out captured as an extra result bit.
module sumador_n #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         caIn,
    output logic [n-1:0] s,
    output logic         caOut
);

    // carry[i] is the carry into bit i; carry[n] leaves the adder.
    logic [n:0] carry;

    assign carry[0] = caIn;

    // One full adder per bit, carry rippling from LSB to MSB.
    for (genvar i = 0; i < n; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign caOut = carry[n];

endmodule : sumador_n

// File: rtl/multiplicador_seq.sv
// Sequential unsigned multiplier, shift-and-add, one partial product per cycle.
// A request in IDLE latches A and B; n CALC cycles each conditionally add
// the multiplicand into the upper half and shift the {acc, mult} pair right;
// the full 2n-bit result is registered on entry to DONE and held until the
// next result or a reset.
module multiplicador_seq
    import mult_pkg::*;
#(
    parameter int n = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [n-1:0]   A,
    input  logic [n-1:0]   B,
    output logic [2*n-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(n - 1);

    state_t        state;
    logic [n-1:0]  mcand;   // latched multiplicand
    logic [n-1:0]  mult;    // multiplier, consumed LSB first; fills with low product bits
    logic [n-1:0]  acc;     // upper half of the running partial product
    logic          cr;      // carry register, shifted out as zero every step
    logic [CW-1:0] cnt;     // index of the current CALC step

    logic [n-1:0]  addend;
    logic [n-1:0]  s;
    logic          c;

    // Add the multiplicand only when the current multiplier bit is set;
    // adding zero with carry-in 0 yields {0, acc} as required.
    assign addend = mult[0] ? mcand : '0;

    sumador_n #(
        .n(n)
    ) u_sumador (
        .a    (acc),
        .b    (addend),
        .caIn (1'b0),
        .s    (s),
        .caOut(c)
    );

    // Status flags come straight from the state register, never from start.
    assign busy = (state == CALC);
    assign done = (state == DONE);

    // Controller and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            product <= '0;
            mcand   <= '0;
            mult    <= '0;
            acc     <= '0;
            cr      <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= A;
                        mult  <= B;
                        acc   <= '0;
                        cr    <= 1'b0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // {cr, acc, mult} <= {0, c, s, mult[n-1:1]}
                    cr   <= 1'b0;
                    acc  <= {c, s[n-1:1]};
                    mult <= {s[0], mult[n-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        product <= {c, s, mult[n-1:1]};
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The top bit of the shifted pair always receives zero, so cr stays clear.
    cr_stays_zero: assert property (@(posedge clk) cr == 1'b0);

endmodule : multiplicador_seq

// File: tb/tb_multiplicador_seq.sv
// Bench for multiplicador_seq: one n=4 and one n=8 instance, each shadowed
// by a timing/result model; directed literal cases plus exhaustive (n=4)
// and random (n=8) operand sweeps.
module tb_multiplicador_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0;
    logic [3:0] A4 = '0;
    logic [3:0] B4 = '0;
    logic [7:0] product4;
    logic       busy4;
    logic       done4;
    logic       start8 = 1'b0;
    logic [7:0] A8 = '0;
    logic [7:0] B8 = '0;
    logic [15:0] product8;
    logic       busy8;
    logic       done8;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    multiplicador_seq #(.n(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4),
        .product(product4), .busy(busy4), .done(done4)
    );

    multiplicador_seq #(.n(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
        .product(product8), .busy(busy8), .done(done8)
    );

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // k = cycles elapsed since acceptance (-1 when no operation is in flight).
    // Busy for k in [0, n-1], done at k == n, result A*B visible from k == n.
    logic [7:0]  exp_q4[$];
    logic [15:0] exp_q8[$];
    int          k4 = -1;
    int          k8 = -1;
    logic [7:0]  m_prod4 = '0;
    logic [15:0] m_prod8 = '0;

    always @(posedge clk) begin
        if (rst) begin
            k4 <= -1;
            exp_q4.delete();
            m_prod4 <= '0;
        end else if (k4 < 0) begin
            if (start4) begin
                exp_q4.push_back(8'(int'(A4) * int'(B4)));
                k4 <= 0;
            end
        end else if (k4 == 4) begin
            k4 <= -1;
        end else begin
            k4 <= k4 + 1;
            if (k4 == 3) m_prod4 <= exp_q4.pop_front();
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            k8 <= -1;
            exp_q8.delete();
            m_prod8 <= '0;
        end else if (k8 < 0) begin
            if (start8) begin
                exp_q8.push_back(16'(int'(A8) * int'(B8)));
                k8 <= 0;
            end
        end else if (k8 == 8) begin
            k8 <= -1;
        end else begin
            k8 <= k8 + 1;
            if (k8 == 7) m_prod8 <= exp_q8.pop_front();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy4",    64'(busy4),    64'(k4 >= 0 && k4 < 4));
            check("done4",    64'(done4),    64'(k4 == 4));
            check("product4", 64'(product4), 64'(m_prod4));
            check("busy8",    64'(busy8),    64'(k8 >= 0 && k8 < 8));
            check("done8",    64'(done8),    64'(k8 == 8));
            check("product8", 64'(product8), 64'(m_prod8));
        end
    end

    // ---------------- drivers ----------------
    // Issue one n=4 operation; A/B are scrambled and start toggled after
    // acceptance. cyc returns the cycle (accept = 0) in which done was seen.
    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       output logic [7:0] prod, output int cyc);
        @(negedge clk);
        A4 = a; B4 = b; start4 = 1'b1;
        @(negedge clk);
        cyc = 1;
        A4 = 4'($urandom_range(0, 15)); B4 = 4'($urandom_range(0, 15));
        start4 = 1'($urandom_range(0, 1));
        while (!done4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            A4 = 4'($urandom_range(0, 15)); B4 = 4'($urandom_range(0, 15));
            start4 = 1'($urandom_range(0, 1));
        end
        if (!done4) check("timeout4", 64'(cyc), 64'(5));
        start4 = 1'b0;
        prod = product4;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] prod, output int cyc);
        @(negedge clk);
        A8 = a; B8 = b; start8 = 1'b1;
        @(negedge clk);
        cyc = 1;
        A8 = 8'($urandom_range(0, 255)); B8 = 8'($urandom_range(0, 255));
        start8 = 1'($urandom_range(0, 1));
        while (!done8 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            A8 = 8'($urandom_range(0, 255)); B8 = 8'($urandom_range(0, 255));
            start8 = 1'($urandom_range(0, 1));
        end
        if (!done8) check("timeout8", 64'(cyc), 64'(9));
        start8 = 1'b0;
        prod = product8;
    endtask

    // ---------------- main sequence ----------------
    logic [3:0] dir_a[5] = '{4'd15, 4'd13, 4'd0, 4'd1, 4'd7};
    logic [3:0] dir_b[5] = '{4'd15, 4'd11, 4'd9, 4'd15, 4'd6};
    logic [7:0] dir_p[5] = '{8'hE1, 8'h8F, 8'h00, 8'h0F, 8'd42};

    initial begin
        logic [7:0]  p4;
        logic [15:0] p8;
        int          cyc;
        int          first_done;
        int          second_done;
        int          n_done;

        rst = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy4", 64'(busy4), 64'(0));
        check("reset_done4", 64'(done4), 64'(0));
        check("reset_product4", 64'(product4), 64'(0));
        check("reset_product8", 64'(product8), 64'(0));
        rst = 1'b0;

        // Directed literal cases, including A/B changes during CALC.
        for (int i = 0; i < 5; i++) begin
            op4(dir_a[i], dir_b[i], p4, cyc);
            check($sformatf("dir4_product_%0d", i), 64'(p4), 64'(dir_p[i]));
            check($sformatf("dir4_done_cycle_%0d", i), 64'(cyc), 64'(5));
        end

        // Start held high continuously: results back to back every 6 cycles.
        @(negedge clk);
        A4 = 4'd3; B4 = 4'd5; start4 = 1'b1;
        first_done = -1; second_done = -1; n_done = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (done4) begin
                n_done++;
                if (first_done < 0) first_done = c;
                else second_done = c;
                check($sformatf("held_product_c%0d", c), 64'(product4), 64'(15));
            end
        end
        start4 = 1'b0;
        for (int c = 12; c <= 19; c++) begin
            @(negedge clk);
            if (done4) n_done++;
        end
        check("held_first_done", 64'(first_done), 64'(5));
        check("held_second_done", 64'(second_done), 64'(11));
        check("held_done_count", 64'(n_done), 64'(2));

        // Reset in CALC cycle 2 aborts the operation.
        @(negedge clk);
        A4 = 4'd9; B4 = 4'd9; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy4), 64'(0));
        check("abort_done", 64'(done4), 64'(0));
        check("abort_product", 64'(product4), 64'(0));
        n_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'(0));
        op4(4'd9, 4'd9, p4, cyc);
        check("after_abort_product", 64'(p4), 64'(81));

        // Exhaustive n=4 sweep against plain arithmetic.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4(4'(a), 4'(b), p4, cyc);
                check("exh4", 64'(p4), 64'(a * b));
            end
        end

        // n=8: corners then random pairs.
        op8(8'd255, 8'd255, p8, cyc);
        check("dir8_max", 64'(p8), 64'(16'hFE01));
        check("dir8_done_cycle", 64'(cyc), 64'(9));
        op8(8'd0, 8'd200, p8, cyc);
        check("dir8_zero", 64'(p8), 64'(0));
        for (int i = 0; i < 120; i++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            op8(8'(ra), 8'(rb), p8, cyc);
            check("rand8", 64'(p8), 64'(ra * rb));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion before %0t", $time);
        $fatal(1);
    end

endmodule : tb_multiplicador_seq

// File: doc/multiplicador_seq.md
MULTIPLICADOR_SEQ -- requirements
Module: multiplicador_seq

Interface
REQ-001 The block SHALL have parameter n, default 4, giving the operand width in bits (n >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request; acted on only in IDLE.
REQ-005 The block SHALL have port A, input, n bits: unsigned multiplicand, sampled on the accepting edge.
REQ-006 The block SHALL have port B, input, n bits: unsigned multiplier, sampled on the accepting edge.
REQ-007 The block SHALL have port product, output, 2n bits: registered unsigned result A*B.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in CALC.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse, high while in DONE.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-011 In IDLE with start=1, the rising edge SHALL perform all of the following:
- load mcand <= A and mult <= B;
- clear acc (n bits) and carry register cr;
- clear step counter cnt;
- move to CALC.
REQ-012 In IDLE with start=0, the FSM SHALL remain in IDLE and all registers SHALL hold.
REQ-013 Each CALC edge SHALL compute {c, s} = acc + mcand, with carry-in 0, when mult[0]=1, and {c, s} = {0, acc} when mult[0]=0.
REQ-014 The same CALC edge SHALL shift right: {cr, acc, mult} <= {1'b0, c, s, mult[n-1:1]}, and SHALL increment cnt.
REQ-015 When cnt reaches n-1 on a CALC edge, that edge SHALL also load product <= {c, s, mult[n-1:1]} and move to DONE.
REQ-016 CALC SHALL last exactly n cycles; done SHALL be high exactly in cycle n+1, where cycle 0 is the accepting edge.
REQ-017 DONE SHALL last exactly one cycle and then return unconditionally to IDLE; start is ignored in DONE.
REQ-018 start SHALL be ignored in CALC; a held or repeated start SHALL not restart or corrupt the operation.
REQ-019 product SHALL change only on the DONE-entry edge and on reset, and SHALL hold through IDLE until the next result.
REQ-020 Changes on A/B after the accepting edge SHALL have no effect on the current result.
REQ-021 Arithmetic SHALL be unsigned and exact. No overflow is possible: (2^n-1)^2 < 2^(2n).
REQ-022 A new start SHALL be accepted in the cycle immediately after DONE, giving a throughput of one result per n+2 cycles.

Reset
REQ-023 While rst=1 on a rising edge, the block SHALL do all of the following, overriding start:
- set state to IDLE;
- set product=0, busy=0, done=0;
- clear mcand, mult, acc, cr and cnt.
REQ-024 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse; product SHALL read 0 afterward.

Structure
REQ-025 A shared package mult_pkg SHALL hold the state typedef (IDLE/CALC/DONE). No other constants are needed; the counter width is $clog2(n).
REQ-026 The n-bit addition SHALL reuse the team's ripple-carry adder sumador_n as the single sub-module, with caIn tied to 0 and caOut giving c.
REQ-027 busy and done SHALL be decoded from the registered state only, with no combinational path from start.

Verification
REQ-028 n=4, start with A=15, B=15 -> busy high for 4 cycles, done pulse in cycle 5, product=0x00E1.
REQ-029 n=4, A=13, B=11 -> product=143 (0x8F); A=0, B=9 -> product=0; A=1, B=15 -> product=15.
REQ-030 n=4, start held high continuously with A=3, B=5 -> first result 15 with done in cycle 5. Next start accepted in cycle 6, second done in cycle 11, no extra pulses.
REQ-031 n=4, A=7, B=6 accepted, then A/B changed to 15/15 during CALC -> product=42.
REQ-032 n=4, rst asserted in CALC cycle 2 of A=9, B=9 -> next cycle IDLE, busy=0, no done, product=0. New start A=9, B=9 -> product=81.
REQ-033 The bench SHALL compare against A*B for all 256 pairs at n=4 and for random pairs at n=8.
